// File: rtl/clk_mon_pkg.sv
// Shared types and helpers for clk_ratio_monitor.
package clk_mon_pkg;

    // Width of the consecutive-match counter (LOCK_CNT is at most 15).
    localparam int unsigned MatchCntW = 4;

    typedef enum logic [1:0] {
        StUnlocked = 2'd0,
        StAcq      = 2'd1,
        StLocked   = 2'd2
    } mon_state_e;

    // True when |period - exp_ratio| <= tol. The difference is signed and
    // wider than any counter value, so it cannot wrap.
    function automatic logic ratio_match(input int period, input int exp_ratio, input int tol);
        int diff;
        diff = period - exp_ratio;
        if (diff < 0) begin
            diff = -diff;
        end
        return (diff <= tol);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer with registered history for rise/fall pulse detection.
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic sync_dly_q;

    // Synchronizer chain plus one delay stage for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q     <= 1'b0;
            sync_q     <= 1'b0;
            sync_dly_q <= 1'b0;
        end else begin
            meta_q     <= din;
            sync_q     <= meta_q;
            sync_dly_q <= sync_q;
        end
    end

    assign sync = sync_q;
    assign rise = sync_q & ~sync_dly_q;
    assign fall = ~sync_q & sync_dly_q;

endmodule

// File: rtl/clk_ratio_monitor.sv
// Measures the period of an asynchronous slow clock in clk cycles, checks it
// against EXP_RATIO +/- TOL and reports lock / lock loss.
// Define CLK_MON_DUTY_EN to build the high-time counter and duty check;
// otherwise high_time and duty_err are tied to 0.
module clk_ratio_monitor
    import clk_mon_pkg::*;
#(
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned EXP_RATIO = 8,
    parameter int unsigned TOL       = 0,
    parameter int unsigned LOCK_CNT  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_in,
    input  logic             clr,
    output logic [CNT_W-1:0] period,
    output logic             period_vld,
    output logic [CNT_W-1:0] high_time,
    output logic             locked,
    output logic             lost,
    output logic             overflow,
    output logic             duty_err
);

    localparam logic [CNT_W-1:0]     CntMax   = '1;
    localparam int unsigned          Timeout  = EXP_RATIO + TOL + 1;
    localparam logic [MatchCntW-1:0] LockCntL = MatchCntW'(LOCK_CNT);

    logic sync_s;
    logic rise;
    logic fall_unused;

    sync_edge_det u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (clk_in),
        .sync  (sync_s),
        .rise  (rise),
        .fall  (fall_unused)
    );

    mon_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     period_q, period_d;
    logic                 vld_q, vld_d;
    logic [MatchCntW-1:0] match_q, match_d;
    logic                 lost_q, lost_d;
    logic                 ovf_q, ovf_d;
    logic                 high_ovf;
    logic                 period_match;
    logic                 timeout;

    // A saturated period never matches, even with a large tolerance.
    assign period_match = ratio_match(int'(period_q), int'(EXP_RATIO), int'(TOL)) &&
                          (period_q != CntMax);
    assign timeout      = !rise && (int'(cnt_q) >= int'(Timeout));

    // Period counter, measurement capture and lock FSM next-state.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        vld_d    = 1'b0;
        match_d  = match_q;
        lost_d   = 1'b0;
        ovf_d    = ovf_q;
        if (clr) begin
            // clr wins over a coincident rise; the edge is dropped.
            state_d  = StUnlocked;
            cnt_d    = '0;
            period_d = '0;
            match_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (rise) begin
                cnt_d = CNT_W'(1);
                // The first edge after unlock has no reference edge to measure from.
                if (state_q != StUnlocked) begin
                    period_d = cnt_q;
                    vld_d    = 1'b1;
                end
            end else if (cnt_q == CntMax) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            if (high_ovf) begin
                ovf_d = 1'b1;
            end
            unique case (state_q)
                StUnlocked: begin
                    if (rise) begin
                        state_d = StAcq;
                    end
                end
                StAcq: begin
                    if (vld_q) begin
                        if (period_match) begin
                            match_d = match_q + 1'b1;
                            if (match_q + 1'b1 == LockCntL) begin
                                state_d = StLocked;
                            end
                        end else begin
                            match_d = '0;
                        end
                    end
                end
                StLocked: begin
                    if ((vld_q && !period_match) || timeout) begin
                        state_d = StUnlocked;
                        match_d = '0;
                        lost_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = StUnlocked;
                    match_d = '0;
                end
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StUnlocked;
            cnt_q    <= '0;
            period_q <= '0;
            vld_q    <= 1'b0;
            match_q  <= '0;
            lost_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            vld_q    <= vld_d;
            match_q  <= match_d;
            lost_q   <= lost_d;
            ovf_q    <= ovf_d;
        end
    end

`ifdef CLK_MON_DUTY_EN
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             duty_q, duty_d;

    // High-time counter, latched alongside the period; duty errors are sticky.
    always_comb begin
        hcnt_d   = hcnt_q;
        high_d   = high_q;
        duty_d   = duty_q;
        high_ovf = 1'b0;
        if (clr) begin
            hcnt_d = '0;
            high_d = '0;
            duty_d = 1'b0;
        end else begin
            if (rise) begin
                // The rise cycle itself is the first high cycle of the new period.
                hcnt_d = CNT_W'(1);
                if (state_q != StUnlocked) begin
                    high_d = hcnt_q;
                end
            end else if (sync_s) begin
                if (hcnt_q == CntMax) begin
                    high_ovf = 1'b1;
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            if (vld_q && !ratio_match(int'(high_q), int'(EXP_RATIO / 2), int'(TOL))) begin
                duty_d = 1'b1;
            end
        end
    end

    // Duty measurement registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q <= '0;
            high_q <= '0;
            duty_q <= 1'b0;
        end else begin
            hcnt_q <= hcnt_d;
            high_q <= high_d;
            duty_q <= duty_d;
        end
    end

    assign high_time = high_q;
    assign duty_err  = duty_q;
`else
    logic sync_unused;

    assign sync_unused = sync_s;
    assign high_ovf    = 1'b0;
    assign high_time   = '0;
    assign duty_err    = 1'b0;
`endif

    assign period     = period_q;
    assign period_vld = vld_q;
    assign locked     = (state_q == StLocked);
    assign lost       = lost_q;
    assign overflow   = ovf_q;

endmodule

// File: doc/clk_ratio_monitor.md
# clk_ratio_monitor

Receive-side checker for divided clocks generated by the workshop divider blocks. It samples a slow, asynchronous clock input (e.g. clk/8) in the fast clk domain and measures its period in clk cycles. It compares that period against an expected ratio and reports lock and lock-loss. It sits beside each divider output in the top-level test designs as a self-check on the generated clock.

## Interface
Parameters:
- CNT_W, 8: width of period/high-time counters; saturate at 2^CNT_W-1
- EXP_RATIO, 8: expected period of clk_in in clk cycles (≥4, < 2^CNT_W-1)
- TOL, 0: accepted ± deviation in cycles for period and duty checks
- LOCK_CNT, 4: consecutive matching periods required to declare lock (1..15)

Ports:
- clk  in  1  system clock; all logic on posedge
- rst_n  in  1  reset, asynchronous, active-low
- clk_in  in  1  monitored clock, asynchronous to clk
- clr  in  1  synchronous clear of FSM, counters, sticky flags
- period  out  CNT_W  last measured period in clk cycles
- period_vld  out  1  one-cycle pulse when period updates
- high_time  out  CNT_W  clk cycles clk_in was high in last period
- locked  out  1  level; ratio verified
- lost  out  1  one-cycle pulse on LOCKED→UNLOCKED
- overflow  out  1  sticky; counter saturated at least once
- duty_err  out  1  sticky; high_time outside EXP_RATIO/2 ± TOL

## Operation
- Input path: 2-FF synchronizer on clk_in, then 1 register for rising-edge detect (rise = s & ~s_d).
- Period counter cnt: on rise, period <= cnt, cnt <= 1. Otherwise, cnt increments and saturates at all-ones. The saturating increment sets overflow.
- A period is a match when |period − EXP_RATIO| ≤ TOL. A saturated value never matches.
- FSM states: UNLOCKED, ACQ, LOCKED.
  - UNLOCKED: the first rise goes to ACQ and starts cnt. No period_vld on this rise, because there is no reference edge.
  - ACQ: every rise pulses period_vld.
    - A match increments match_cnt. When match_cnt reaches LOCK_CNT, go to LOCKED.
    - A mismatch sets match_cnt to 0 and stays in ACQ.
  - LOCKED: a mismatching period goes to UNLOCKED with a lost pulse.
    - Timeout also goes to UNLOCKED with a lost pulse. Timeout means cnt reaches EXP_RATIO+TOL+1 with no rise.
    - On exit, match_cnt clears and the next rise behaves as in UNLOCKED.
- clr returns the FSM to UNLOCKED and zeroes cnt, match_cnt, period, high_time, overflow and duty_err. clr never produces a lost pulse.
- Arithmetic: the match comparison uses CNT_W+1-bit signed difference; no wrap.

## Timing
- Reset values: period=0, period_vld=0, high_time=0, locked=0, lost=0, overflow=0, duty_err=0, FSM=UNLOCKED, cnt=0.
- Latency from a clk_in rising edge to rise is 2–3 clk cycles (synchronizer). period/period_vld register in the cycle after rise.
- locked rises in the cycle after the period_vld that carries the LOCK_CNT-th consecutive match.
- On mismatch exit, locked falls and lost pulses in the cycle after the failing period_vld. On timeout, they occur the cycle after cnt reaches the limit.
- clr together with a rise: clr wins and the edge is discarded.
- rst_n asserted mid-operation: all outputs return to reset values immediately (async). Measurement restarts at the first rise after release.
- clk_in pulses shorter than 2 clk cycles may be missed. This is accepted and shows up as a mismatch.

## Configuration
- CLK_MON_DUTY_EN defined:
  - A high counter increments while the synchronized clk_in is high and saturates.
  - On rise, high_time latches the counter and the counter restarts.
  - If |high_time − EXP_RATIO/2| > TOL on a valid period, duty_err sets (sticky). Duty errors do not affect lock.
- CLK_MON_DUTY_EN undefined: high_time and duty_err are tied to 0 and the high counter is not built. Ports remain for a stable interface.

## Structure
- Package clk_mon_pkg: state enum typedef (UNLOCKED/ACQ/LOCKED), match_cnt width constant (4 bits), and a ratio_match(period, exp, tol) function.
- Sub-module sync_edge_det: 2-FF synchronizer plus rise/fall pulse outputs, reusable by other CDC blocks.

## Test plan
- clk_in = clk/8 (toggles every 4 clk), default params:
  - period=8 on every period_vld, with the first period_vld on the 2nd rise.
  - locked=1 after the 5th rise; overflow=0.
  - With duty feature enabled: high_time=4, duty_err=0.
- Locked, then clk_in switches to clk/6 → next period_vld period=6, locked=0 and a 1-cycle lost pulse the following cycle.
- Locked, then clk_in stuck low → lost pulse once cnt reaches 9 (TOL=0); period keeps its last value 8.
- clk_in stuck low from reset for 300 cycles with CNT_W=8 → overflow=1, locked=0, no period_vld.
- ACQ with 3 matches, then one period of 10 → match_cnt restarts; locked only after 4 further matches of 8.
- Reset and clear:
  - rst_n pulsed low while locked → all outputs 0 immediately.
  - clr coincident with a rise → no period_vld and state UNLOCKED.
  - With duty feature enabled, a 6/2 high/low pattern → duty_err=1.
